fetch_control: RTL and testbench
================================

FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter NB, default 32, the PC / address width in bits.
REQ-002 SHALL have port i_clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_pc  input  NB  current PC from the program counter register.
REQ-005 SHALL have port i_stall  input  1  hazard-unit stall request.
REQ-006 SHALL have port i_jump  input  1  jump redirect valid.
REQ-007 SHALL have port i_jump_target  input  NB  jump target address.
REQ-008 SHALL have port i_branch_taken  input  1  branch resolved taken.
REQ-009 SHALL have port i_branch_target  input  NB  branch target address.
REQ-010 SHALL have port i_halt_detected  input  1  HALT instruction decoded.
REQ-011 SHALL have port i_run  input  1  debug command: free run.
REQ-012 SHALL have port i_step  input  1  debug command: advance one cycle.
REQ-013 SHALL have port i_pause  input  1  debug command: pause.
REQ-014 SHALL have port o_write_new_pc  output  1  PC write enable.
REQ-015 SHALL have port o_new_pc  output  NB  next PC value.
REQ-016 SHALL have port o_flush  output  1  flush the IF/ID register.
REQ-017 SHALL have port o_state  output  3  FSM state encoding.
REQ-018 SHALL have port o_halted  output  1  high while in HALTED.
REQ-019 SHALL have port o_cycle_count  output  32  count of executed (advance) cycles.

Function
REQ-020 SHALL implement states IDLE=0, RUN=1, STEP=2, PAUSE=3, HALTED=4 (the o_state encoding).
REQ-021 SHALL transition IDLE/PAUSE -> RUN on i_run; else IDLE/PAUSE -> STEP on i_step; i_run has priority when both are high.
REQ-022 SHALL transition STEP -> PAUSE unconditionally after exactly one cycle.
REQ-023 SHALL transition RUN -> PAUSE on i_pause.
REQ-024 SHALL transition RUN/STEP -> HALTED on i_halt_detected; halt has priority over i_pause and over the STEP -> PAUSE transition.
REQ-025 SHALL remain in HALTED until reset and ignore i_run, i_step and i_pause there.
REQ-026 SHALL define "advance" as (state is RUN or STEP) AND NOT i_stall AND NOT i_halt_detected.
REQ-027 SHALL drive o_write_new_pc = advance, combinationally.
REQ-028 SHALL select o_new_pc by priority: i_jump_target if i_jump, else i_branch_target if i_branch_taken, else i_pc + 4 (modulo 2^NB, wrapping at the top); output is combinational.
REQ-029 SHALL assert o_flush = advance AND (i_jump OR i_branch_taken).
REQ-030 SHALL keep o_write_new_pc and o_flush at 0 in IDLE, PAUSE and HALTED regardless of other inputs.
REQ-031 SHALL increment o_cycle_count by 1 on each advance cycle, wrapping from 0xFFFFFFFF to 0.
REQ-032 SHALL hold o_cycle_count on stall cycles; a STEP cycle that is stalled still consumes the step (STEP -> PAUSE) without counting.
REQ-033 SHALL register o_state, o_halted and o_cycle_count.

Reset
REQ-034 SHALL, on i_reset high, asynchronously force state = IDLE, o_halted = 0 and o_cycle_count = 0, including mid-RUN, mid-STEP and in HALTED.
REQ-035 SHALL hold o_write_new_pc = 0 and o_flush = 0 while i_reset is high.
REQ-036 SHALL resume normal operation on the first rising edge after i_reset deasserts, starting from IDLE.

Verification
REQ-037 SHALL cover: reset, i_run pulse, i_pc=0x0 -> RUN, o_write_new_pc=1, o_new_pc=0x4, o_cycle_count reaches 3 after 3 cycles.
REQ-038 SHALL cover: in RUN, i_jump=1 with jump target 0x40 and i_branch_taken=1 with branch target 0x80 together -> o_new_pc=0x40, o_flush=1.
REQ-039 SHALL cover: in RUN, i_stall=1 for 2 cycles -> o_write_new_pc=0, o_flush=0, o_cycle_count unchanged.
REQ-040 SHALL cover: PAUSE, i_step pulse -> exactly one cycle with o_write_new_pc=1, then o_state=3 and o_cycle_count +1.
REQ-041 SHALL cover: in RUN, i_halt_detected=1 and i_pause=1 together -> o_state=4, o_halted=1, o_write_new_pc=0; a following i_run has no effect.
REQ-042 SHALL cover: i_pc=0xFFFFFFFC -> o_new_pc=0x0; i_reset asserted mid-RUN -> o_state=0 and o_cycle_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_control.sv
// Fetch-stage controller: debug run/step/pause FSM, next-PC selection with
// jump/branch redirect, IF/ID flush and an executed-cycle counter.
module fetch_control #(
    parameter int unsigned NB = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [NB-1:0] i_pc,
    input  logic          i_stall,
    input  logic          i_jump,
    input  logic [NB-1:0] i_jump_target,
    input  logic          i_branch_taken,
    input  logic [NB-1:0] i_branch_target,
    input  logic          i_halt_detected,
    input  logic          i_run,
    input  logic          i_step,
    input  logic          i_pause,
    output logic          o_write_new_pc,
    output logic [NB-1:0] o_new_pc,
    output logic          o_flush,
    output logic [2:0]    o_state,
    output logic          o_halted,
    output logic [31:0]   o_cycle_count
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StPause  = 3'd3,
        StHalted = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        advance;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StPause: begin
                if (i_run) begin
                    state_d = StRun;
                end else if (i_step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (i_halt_detected) begin
                    state_d = StHalted;
                end else if (i_pause) begin
                    state_d = StPause;
                end
            end
            // A step is consumed even when stalled.
            StStep: begin
                state_d = i_halt_detected ? StHalted : StPause;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        advance = 1'b0;
        if ((state_q == StRun) || (state_q == StStep)) begin
            advance = !i_stall && !i_halt_detected && !i_reset;
        end
    end

    always_comb begin
        o_new_pc = i_pc + NB'(4);
        if (i_jump) begin
            o_new_pc = i_jump_target;
        end else if (i_branch_taken) begin
            o_new_pc = i_branch_target;
        end
    end

    always_comb begin
        o_write_new_pc = advance;
        o_flush        = advance && (i_jump || i_branch_taken);
        halted_d       = (state_d == StHalted);
        cycle_count_d  = advance ? cycle_count_q + 32'd1 : cycle_count_q;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= StIdle;
            halted_q      <= 1'b0;
            cycle_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign o_state       = state_q;
    assign o_halted      = halted_q;
    assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: expectations are queued per step and
// popped against the DUT outputs at each sampling point.
`timescale 1ns/1ps
module tb_fetch_control;

    localparam int SigState  = 0;
    localparam int SigHalted = 1;
    localparam int SigCount  = 2;
    localparam int SigWr     = 3;
    localparam int SigNewPc  = 4;
    localparam int SigFlush  = 5;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_halt_detected;
    logic        i_run;
    logic        i_step;
    logic        i_pause;
    logic        o_write_new_pc;
    logic [31:0] o_new_pc;
    logic        o_flush;
    logic [2:0]  o_state;
    logic        o_halted;
    logic [31:0] o_cycle_count;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    fetch_control #(.NB(32)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_pc           (i_pc),
        .i_stall        (i_stall),
        .i_jump         (i_jump),
        .i_jump_target  (i_jump_target),
        .i_branch_taken (i_branch_taken),
        .i_branch_target(i_branch_target),
        .i_halt_detected(i_halt_detected),
        .i_run          (i_run),
        .i_step         (i_step),
        .i_pause        (i_pause),
        .o_write_new_pc (o_write_new_pc),
        .o_new_pc       (o_new_pc),
        .o_flush        (o_flush),
        .o_state        (o_state),
        .o_halted       (o_halted),
        .o_cycle_count  (o_cycle_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SigState:  return {29'd0, o_state};
            SigHalted: return {31'd0, o_halted};
            SigCount:  return o_cycle_count;
            SigWr:     return {31'd0, o_write_new_pc};
            SigNewPc:  return o_new_pc;
            SigFlush:  return {31'd0, o_flush};
            default:   return 32'hdead_beef;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_pc = 32'h0;
        i_stall = 1'b0;
        i_jump = 1'b0;
        i_jump_target = 32'h40;
        i_branch_taken = 1'b0;
        i_branch_target = 32'h80;
        i_halt_detected = 1'b0;
        i_run = 1'b1;
        i_step = 1'b0;
        i_pause = 1'b0;

        // Reset held, run request ignored.
        #3;
        push_exp("rst_state", SigState, 32'd0);
        push_exp("rst_halted", SigHalted, 32'd0);
        push_exp("rst_count", SigCount, 32'd0);
        push_exp("rst_wr", SigWr, 32'd0);
        push_exp("rst_flush", SigFlush, 32'd0);
        check_all();
        tick();
        tick();
        push_exp("rst_hold_state", SigState, 32'd0);
        push_exp("rst_hold_wr", SigWr, 32'd0);
        check_all();

        // Release and enter RUN.
        i_reset = 1'b0;
        tick();
        i_run = 1'b0;
        #1;
        push_exp("run_state", SigState, 32'd1);
        push_exp("run_wr", SigWr, 32'd1);
        push_exp("run_new_pc", SigNewPc, 32'h4);
        push_exp("run_flush", SigFlush, 32'd0);
        push_exp("run_count0", SigCount, 32'd0);
        check_all();
        tick();
        tick();
        tick();
        push_exp("run_count3", SigCount, 32'd3);
        check_all();

        // Jump beats branch.
        i_jump = 1'b1;
        i_branch_taken = 1'b1;
        #1;
        push_exp("jump_new_pc", SigNewPc, 32'h40);
        push_exp("jump_flush", SigFlush, 32'd1);
        push_exp("jump_wr", SigWr, 32'd1);
        check_all();
        tick();
        i_jump = 1'b0;
        #1;
        push_exp("branch_new_pc", SigNewPc, 32'h80);
        push_exp("branch_flush", SigFlush, 32'd1);
        push_exp("branch_count", SigCount, 32'd4);
        check_all();
        tick();
        i_branch_taken = 1'b0;

        // Stall two cycles with a redirect pending.
        i_stall = 1'b1;
        i_jump = 1'b1;
        #1;
        push_exp("stall_wr", SigWr, 32'd0);
        push_exp("stall_flush", SigFlush, 32'd0);
        check_all();
        tick();
        tick();
        push_exp("stall_count", SigCount, 32'd5);
        push_exp("stall_state", SigState, 32'd1);
        push_exp("stall_wr2", SigWr, 32'd0);
        check_all();
        i_stall = 1'b0;
        i_jump = 1'b0;

        // Pause from RUN; the pausing cycle still advances.
        i_pause = 1'b1;
        tick();
        i_pause = 1'b0;
        i_jump = 1'b1;
        #1;
        push_exp("pause_state", SigState, 32'd3);
        push_exp("pause_count", SigCount, 32'd6);
        push_exp("pause_wr", SigWr, 32'd0);
        push_exp("pause_flush", SigFlush, 32'd0);
        check_all();
        i_jump = 1'b0;

        // Single step.
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        #1;
        push_exp("step_state", SigState, 32'd2);
        push_exp("step_wr", SigWr, 32'd1);
        push_exp("step_count_before", SigCount, 32'd6);
        check_all();
        tick();
        push_exp("step_done_state", SigState, 32'd3);
        push_exp("step_done_count", SigCount, 32'd7);
        push_exp("step_done_wr", SigWr, 32'd0);
        check_all();

        // Stalled step is consumed without counting.
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        i_stall = 1'b1;
        #1;
        push_exp("sstep_state", SigState, 32'd2);
        push_exp("sstep_wr", SigWr, 32'd0);
        check_all();
        tick();
        push_exp("sstep_done_state", SigState, 32'd3);
        push_exp("sstep_done_count", SigCount, 32'd7);
        check_all();
        i_stall = 1'b0;

        // Halt beats pause; halted ignores debug commands.
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        i_halt_detected = 1'b1;
        i_pause = 1'b1;
        #1;
        push_exp("halt_req_state", SigState, 32'd1);
        push_exp("halt_req_wr", SigWr, 32'd0);
        check_all();
        tick();
        i_halt_detected = 1'b0;
        i_pause = 1'b0;
        #1;
        push_exp("halt_state", SigState, 32'd4);
        push_exp("halt_halted", SigHalted, 32'd1);
        push_exp("halt_count", SigCount, 32'd7);
        push_exp("halt_wr", SigWr, 32'd0);
        check_all();
        i_run = 1'b1;
        i_step = 1'b1;
        tick();
        tick();
        #1;
        push_exp("halt_sticky_state", SigState, 32'd4);
        push_exp("halt_sticky_halted", SigHalted, 32'd1);
        push_exp("halt_sticky_wr", SigWr, 32'd0);
        check_all();
        i_run = 1'b0;
        i_step = 1'b0;

        // PC wrap.
        i_pc = 32'hFFFF_FFFC;
        #1;
        push_exp("pc_wrap", SigNewPc, 32'h0);
        check_all();
        i_pc = 32'h0;

        // Reset out of HALTED.
        i_reset = 1'b1;
        #1;
        push_exp("rst_halt_state", SigState, 32'd0);
        push_exp("rst_halt_halted", SigHalted, 32'd0);
        push_exp("rst_halt_count", SigCount, 32'd0);
        check_all();
        tick();
        i_reset = 1'b0;
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        tick();
        tick();
        #1;
        push_exp("rerun_state", SigState, 32'd1);
        push_exp("rerun_count", SigCount, 32'd2);
        check_all();

        // Asynchronous reset mid-RUN, between clock edges.
        #1;
        i_reset = 1'b1;
        #1;
        push_exp("async_rst_state", SigState, 32'd0);
        push_exp("async_rst_count", SigCount, 32'd0);
        push_exp("async_rst_wr", SigWr, 32'd0);
        push_exp("async_rst_flush", SigFlush, 32'd0);
        check_all();
        tick();
        i_reset = 1'b0;
        tick();
        push_exp("post_rst_idle", SigState, 32'd0);
        push_exp("post_rst_wr", SigWr, 32'd0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
